// File: rtl/mem_pkg.sv
// Shared definitions for the multi-port word memory: default geometry, FSM
// encodings and the byte-strobe merge used by the write path and forwarding.
package mem_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 15;

    // Widest word the merge helper handles; callers zero-extend and truncate.
    localparam int MERGE_MAX_W = 512;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } mem_state_e;

    function automatic logic [MERGE_MAX_W-1:0] strb_merge(
        input logic [MERGE_MAX_W-1:0]   old_word,
        input logic [MERGE_MAX_W-1:0]   new_word,
        input logic [MERGE_MAX_W/8-1:0] strb
    );
        logic [MERGE_MAX_W-1:0] merged;
        merged = old_word;
        for (int b = 0; b < MERGE_MAX_W/8; b++) begin
            if (strb[b]) merged[8*b +: 8] = new_word[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/mem_rd_port.sv
// One read port: stage-A address register, output data register and valid
// pipeline, with optional same-edge write forwarding into the data register.
module mem_rd_port
    import mem_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int RAW_MODE = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ready,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   raddr,
    input  logic                wr_commit,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic [DATA_W-1:0]   arr_word,
    output logic [ADDR_W-1:0]   addr_a,
    output logic                occupied,
    output logic [DATA_W-1:0]   rdata,
    output logic                rvalid
);

    logic              fwd_hit;
    logic [DATA_W-1:0] next_word;

    // A write committing on the array-read edge lands in the same cycle, so
    // the new bytes must be merged here to be seen.
    assign fwd_hit   = (RAW_MODE != 0) && wr_commit && (waddr == addr_a);
    assign next_word = fwd_hit
        ? DATA_W'(strb_merge(MERGE_MAX_W'(arr_word), MERGE_MAX_W'(wdata),
                             (MERGE_MAX_W/8)'(wstrb)))
        : arr_word;

    always_ff @(posedge clk) begin
        if (reset) begin
            occupied <= 1'b0;
            addr_a   <= '0;
            rdata    <= '0;
            rvalid   <= 1'b0;
        end else begin
            occupied <= ready && rd_en;
            if (ready && rd_en) addr_a <= raddr;
            rvalid <= occupied;
            if (occupied) rdata <= next_word;
        end
    end

endmodule

// File: rtl/mem_mp.sv
// Multi-port word memory: NUM_RD 2-cycle read ports, one byte-strobed write
// port, optional zeroing sweep after reset.
//   state   | meaning
//   S_CLEAR | after reset; zeroing one word per cycle (or passing straight through)
//   S_RUN   | ready, accepting reads and writes
module mem_mp
    import mem_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int NUM_RD         = 2,
    parameter int RAW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     ready,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rvalid,
    input  logic                     wen,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [DATA_W/8-1:0]      wstrb
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    mem_state_e        state, state_nxt;
    logic [ADDR_W-1:0] clr_addr;
    logic              sweep_we;
    logic              wr_commit;
    logic [ADDR_W-1:0] addr_a    [NUM_RD];
    logic [DATA_W-1:0] arr_word  [NUM_RD];
    logic [NUM_RD-1:0] occupancy;

    assign ready     = (state == S_RUN);
    assign wr_commit = ready && wen && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_CLEAR;
            clr_addr <= '0;
        end else begin
            state <= state_nxt;
            if (sweep_we) clr_addr <= clr_addr + ADDR_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        sweep_we  = 1'b0;
        case (state)
            S_CLEAR: begin
                if (CLEAR_ON_RESET == 0) begin
                    state_nxt = S_RUN;
                end else begin
                    sweep_we = 1'b1;
                    if (clr_addr == '1) state_nxt = S_RUN;
                end
            end
            S_RUN:   state_nxt = S_RUN;
            default: state_nxt = S_CLEAR;
        endcase
    end

    // The array itself is never reset; only the sweep zeroes it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (sweep_we) begin
                mem[clr_addr] <= '0;
            end else if (wr_commit) begin
                mem[waddr] <= DATA_W'(strb_merge(MERGE_MAX_W'(mem[waddr]),
                                                 MERGE_MAX_W'(wdata),
                                                 (MERGE_MAX_W/8)'(wstrb)));
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        assign arr_word[i] = occupancy[i] ? mem[addr_a[i]] : '0;

        mem_rd_port #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .RAW_MODE(RAW_MODE)
        ) u_port (
            .clk      (clk),
            .reset    (reset),
            .ready    (ready),
            .rd_en    (rd_en[i]),
            .raddr    (raddr[i*ADDR_W +: ADDR_W]),
            .wr_commit(wr_commit),
            .waddr    (waddr),
            .wdata    (wdata),
            .wstrb    (wstrb),
            .arr_word (arr_word[i]),
            .addr_a   (addr_a[i]),
            .occupied (occupancy[i]),
            .rdata    (rdata[i*DATA_W +: DATA_W]),
            .rvalid   (rvalid[i])
        );
    end

endmodule

// File: tb/tb_mem_mp.sv
// Bench for mem_mp: two instances (old-data and forwarding read-during-write)
// share stimulus; a memory model feeds per-port expected queues.
module tb_mem_mp;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int NUM_RD = 2;
    localparam int DEPTH  = 16;
    localparam int NQ     = 2 * NUM_RD;

    logic                     clk = 1'b0;
    logic                     reset = 1'b0;
    logic [NUM_RD-1:0]        rd_en = '0;
    logic [NUM_RD*ADDR_W-1:0] raddr = '0;
    logic                     wen = 1'b0;
    logic [ADDR_W-1:0]        waddr = '0;
    logic [DATA_W-1:0]        wdata = '0;
    logic [DATA_W/8-1:0]      wstrb = '0;
    logic                     ready0, ready1;
    logic [NUM_RD*DATA_W-1:0] rdata0, rdata1;
    logic [NUM_RD-1:0]        rvalid0, rvalid1;

    mem_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD),
             .RAW_MODE(0), .CLEAR_ON_RESET(1)) u_raw0 (
        .clk(clk), .reset(reset), .ready(ready0), .rd_en(rd_en), .raddr(raddr),
        .rdata(rdata0), .rvalid(rvalid0), .wen(wen), .waddr(waddr),
        .wdata(wdata), .wstrb(wstrb));

    mem_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD),
             .RAW_MODE(1), .CLEAR_ON_RESET(1)) u_raw1 (
        .clk(clk), .reset(reset), .ready(ready1), .rd_en(rd_en), .raddr(raddr),
        .rdata(rdata1), .rvalid(rvalid1), .wen(wen), .waddr(waddr),
        .wdata(wdata), .wstrb(wstrb));

    always #5 clk = ~clk;

    int   cyc = 0;
    logic rst_d = 1'b0;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_d <= reset;
    end

    typedef struct { logic [DATA_W-1:0] data; int due; } exp_t;
    typedef struct { int port; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] e0; int due; } pend_t;

    exp_t  sb [NQ][$];
    pend_t pend[$];

    logic [DATA_W-1:0] m_mem [DEPTH];
    logic m_ready = 1'b0;
    int   m_sweep = 0;
    logic m_known = 1'b0;
    logic done    = 1'b0;

    int checks = 0;
    int errors = 0;

    // One clock of stimulus. Reads accepted now return the memory as it stands
    // after this cycle's write (old-data mode) or after next cycle's write
    // (forwarding mode), two edges later.
    task automatic step(input logic rst, input logic [NUM_RD-1:0] re,
                        input logic [NUM_RD*ADDR_W-1:0] ra, input logic we,
                        input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                        input logic [DATA_W/8-1:0] ws);
        logic acc;
        logic [ADDR_W-1:0] a;
        reset = rst; rd_en = re; raddr = ra;
        wen = we; waddr = wa; wdata = wd; wstrb = ws;
        acc = m_ready && !rst;
        if (acc && we)
            for (int b = 0; b < DATA_W/8; b++)
                if (ws[b]) m_mem[wa][8*b +: 8] = wd[8*b +: 8];
        if (!rst)
            foreach (pend[j]) begin
                sb[pend[j].port].push_back('{pend[j].e0, pend[j].due});
                sb[NUM_RD + pend[j].port].push_back('{m_mem[pend[j].addr], pend[j].due});
            end
        pend.delete();
        if (acc)
            for (int p = 0; p < NUM_RD; p++)
                if (re[p]) begin
                    a = ra[p*ADDR_W +: ADDR_W];
                    pend.push_back('{p, a, m_mem[a], cyc + 2});
                end
        @(posedge clk);
        #1;
        if (rst) begin
            m_ready = 1'b0;
            m_sweep = DEPTH;
            m_known = 1'b1;
        end else if (m_sweep > 0) begin
            m_sweep--;
            if (m_sweep == 0) begin
                m_ready = 1'b1;
                for (int k = 0; k < DEPTH; k++) m_mem[k] = '0;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, '0, '0, 1'b0, '0, '0, '0);
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                      input logic [DATA_W/8-1:0] s);
        step(1'b0, '0, '0, 1'b1, a, d, s);
    endtask

    task automatic rd(input logic [NUM_RD-1:0] re, input logic [ADDR_W-1:0] a0,
                      input logic [ADDR_W-1:0] a1);
        step(1'b0, re, {a1, a0}, 1'b0, '0, '0, '0);
    endtask

    task automatic junk();
        step(1'b0, '1, 8'($urandom), 1'b1, 4'($urandom), 16'($urandom), '1);
    endtask

    task automatic wait_ready_junk();
        int n = 0;
        while (!m_ready && n < 4 * DEPTH) begin
            junk();
            n++;
        end
    endtask

    initial begin
        logic rr;
        repeat (3) step(1'b1, '0, '0, 1'b0, '0, '0, '0);
        wait_ready_junk();
        for (int a = 0; a < DEPTH; a++) wr(4'(a), 16'hFFFF, 2'b11);
        step(1'b1, '0, '0, 1'b0, '0, '0, '0);
        repeat (8) junk();
        step(1'b1, '0, '0, 1'b0, '0, '0, '0);
        wait_ready_junk();
        for (int a = 0; a < DEPTH; a++) rd(2'b11, 4'(a), 4'(DEPTH - 1 - a));
        idle(3);

        wr(4'd3, 16'h1234, 2'b11);
        wr(4'd7, 16'hABCD, 2'b11);
        rd(2'b11, 4'd3, 4'd7);
        rd(2'b11, 4'd7, 4'd3);
        idle(3);

        wr(4'd5, 16'hAAAA, 2'b11);
        wr(4'd5, 16'h1234, 2'b01);
        rd(2'b01, 4'd5, 4'd0);
        wr(4'd5, 16'h5555, 2'b00);
        rd(2'b10, 4'd0, 4'd5);
        idle(3);

        wr(4'd9, 16'h1111, 2'b11);
        idle(1);
        rd(2'b01, 4'd9, 4'd0);
        wr(4'd9, 16'h2222, 2'b11);
        idle(3);

        rd(2'b11, 4'd9, 4'd5);
        step(1'b1, '0, '0, 1'b0, '0, '0, '0);
        step(1'b1, '0, '0, 1'b0, '0, '0, '0);
        wait_ready_junk();
        idle(3);

        repeat (400) begin
            rr = ($urandom_range(0, 99) == 0);
            step(rr, 2'($urandom), 8'($urandom), 1'($urandom), 4'($urandom),
                 16'($urandom), 2'($urandom));
        end
        wait_ready_junk();
        idle(4);
        done = 1'b1;
    end

    logic [DATA_W-1:0] last_exp [NQ];
    initial for (int i = 0; i < NQ; i++) last_exp[i] = '0;

    always @(negedge clk) begin : mon
        int i;
        logic v;
        logic [DATA_W-1:0] dat;
        exp_t e;
        if (m_known) begin
            checks++;
            if (ready0 !== m_ready || ready1 !== m_ready) begin
                errors++;
                $display("FAIL ready cyc %0d: got %b/%b want %b", cyc, ready0, ready1, m_ready);
            end
            for (int d = 0; d < 2; d++)
                for (int p = 0; p < NUM_RD; p++) begin
                    i   = d * NUM_RD + p;
                    v   = (d == 0) ? rvalid0[p] : rvalid1[p];
                    dat = (d == 0) ? rdata0[p*DATA_W +: DATA_W] : rdata1[p*DATA_W +: DATA_W];
                    if (rst_d) last_exp[i] = '0;
                    checks++;
                    if (v === 1'b1) begin
                        if (sb[i].size() == 0) begin
                            errors++;
                            $display("FAIL unexpected rvalid raw%0d port%0d cyc %0d: got data %h, want no pulse", d, p, cyc, dat);
                            last_exp[i] = dat;
                        end else begin
                            e = sb[i].pop_front();
                            if (e.due != cyc || dat !== e.data) begin
                                errors++;
                                $display("FAIL rdata raw%0d port%0d: got %h at cyc %0d, want %h at cyc %0d", d, p, dat, cyc, e.data, e.due);
                            end
                            last_exp[i] = e.data;
                        end
                    end else begin
                        if (dat !== last_exp[i] || v !== 1'b0) begin
                            errors++;
                            $display("FAIL hold raw%0d port%0d cyc %0d: got %h valid %b, want %h valid 0", d, p, cyc, dat, v, last_exp[i]);
                        end
                        if (sb[i].size() > 0 && sb[i][0].due <= cyc) begin
                            e = sb[i].pop_front();
                            errors++;
                            $display("FAIL missing rvalid raw%0d port%0d cyc %0d: got none, want %h", d, p, cyc, e.data);
                        end
                    end
                end
        end
        if (done) begin
            for (int q = 0; q < NQ; q++) begin
                checks++;
                if (sb[q].size() != 0) begin
                    errors++;
                    $display("FAIL leftover queue %0d: got %0d entries, want 0", q, sb[q].size());
                end
            end
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout: got no end of stimulus, want finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_mp.md
Name: mem_mp

Overview:
Parametrised multi-port word memory and the next generation of the core's single-read-port RAM. It provides NUM_RD independent read ports, each with a fixed 2-cycle registered latency and a valid flag, plus one write port with byte strobes. A configurable read-during-write forwarding mode and an optional hardware clear sweep after reset are included. It serves as the shared instruction/data store for the parallel cores, with one read port per core.

Parameters:
DATA_W, 16, word width in bits; must be a multiple of 8
ADDR_W, 15, word-address width; DEPTH = 2**ADDR_W
NUM_RD, 2, number of read ports (1..8)
RAW_MODE, 0, 0 = read of the address being written returns old data; 1 = returns newly written (strobe-merged) data
CLEAR_ON_RESET, 1, 1 = zero every word after reset before asserting ready

Ports:
clk  in  1  clock, all logic on posedge
reset  in  1  synchronous, active-high reset
ready  out  1  memory accepting requests; 0 during reset and clear sweep
rd_en  in  NUM_RD  per-port read request
raddr  in  NUM_RD*ADDR_W  port i address at bits [i*ADDR_W +: ADDR_W]
rdata  out  NUM_RD*DATA_W  port i data at bits [i*DATA_W +: DATA_W]
rvalid  out  NUM_RD  port i rdata valid this cycle
wen  in  1  write request
waddr  in  ADDR_W  write word address
wdata  in  DATA_W  write data
wstrb  in  DATA_W/8  byte enables; bit b covers bits [8b+7:8b]

Behaviour:
- Reset (sync, while reset=1): rdata=0, rvalid=0, ready=0, read pipelines flushed, clear counter=0. Memory contents are untouched except by the sweep.
- FSM states are S_CLEAR, S_RUN:
  - reset deassert with CLEAR_ON_RESET=1: S_CLEAR. One word is zeroed per cycle, addresses 0..DEPTH-1, so the sweep lasts DEPTH cycles. ready rises the cycle after address DEPTH-1 is written.
  - CLEAR_ON_RESET=0: S_RUN the first cycle after reset deasserts. Contents are undefined.
  - reset asserted mid-sweep: the sweep restarts at address 0 after deassert.
- While ready=0, rd_en and wen are ignored (no writes, no rvalid) and rdata holds 0.
- Read pipeline per port, with accept cycle T where rd_en=1 and ready=1:
  - T edge: raddr registered (stage A).
  - T+1 edge: array read into rdata register.
  - rdata/rvalid visible during cycle T+2, so latency is 2.
  - The pipeline is fully pipelined: one accept per port per cycle.
- rvalid is a 1-cycle pulse per accepted read. rdata holds its last value when rvalid=0.
- Ports are independent. Same address on several ports returns identical data.
- Write: committed at the edge where wen=1 and ready=1. Only bytes with wstrb set are updated. wstrb=0 means no change.
- Read-during-write: the array-read edge (T+1) coincides with a write edge to the same address:
  - RAW_MODE=0: returns the pre-write word.
  - RAW_MODE=1: returns the old word with the strobed bytes replaced by wdata.
  - A write at edge T (same cycle as the accept) is visible in both modes.
- Address widths are exact; there is no wrap logic, and addresses cover 0..DEPTH-1 fully.
- Debug: per-port occupancy (stage A valid) is exposed as internal wires only, not as ports.

Decomposition:
- Shared package mem_pkg holds:
  - default DATA_W/ADDR_W
  - FSM state encodings S_CLEAR/S_RUN
  - a function for byte-strobe merge (old, new, strb), used by both the write path and forwarding.
- Sub-module mem_rd_port implements one port's stage-A address register, data register, valid pipeline and forwarding compare. It is instantiated NUM_RD times via generate. The array and FSM stay in mem_mp.

Test Plan:
- Clear sweep, ADDR_W=4, CLEAR_ON_RESET=1: preload the array with 0xFFFF via backdoor, pulse reset. Expect ready=0 for exactly 16 cycles after deassert, then reads of all 16 addresses return 0x0000.
- Latency and throughput, NUM_RD=2:
  - Write 0x1234@3 and 0xABCD@7.
  - Read port0 addr3 and port1 addr7 at cycle T, then swapped at T+1.
  - Expect rvalid=2'b11 in cycles T+2 and T+3, with the correct data in each.
- Byte strobes: write 0xAAAA@5 with wstrb=2'b11, then 0x1234@5 with wstrb=2'b01. A read of 5 returns 0xAA34. A write with wstrb=2'b00 leaves it unchanged.
- Read-during-write: mem[9]=0x1111; accept read of 9 at T; write 0x2222@9 (wstrb=2'b11) at T+1. Expect RAW_MODE=0 → rdata=0x1111 and RAW_MODE=1 → rdata=0x2222.
- Ignored while not ready:
  - Assert wen/rd_en during the sweep: no write lands, rvalid stays 0.
  - Reset at sweep address 8: expect 16 fresh clear cycles.
- Reset mid-read: accept reads at T and assert reset at T+1. Expect rvalid=0 and rdata=0 throughout; no stale pulse after ready returns.
